// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetches instruction bytes, resolves flow control locally
// and hands all other instructions to execute.
module fetch_ctrl #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] OP_NOP  = 8'h00,
    parameter logic [WIDTH-1:0] OP_JMP  = 8'hC0,
    parameter logic [WIDTH-1:0] OP_JZ   = 8'hC1,
    parameter logic [WIDTH-1:0] OP_CALL = 8'hC2,
    parameter logic [WIDTH-1:0] OP_RET  = 8'hC3,
    parameter logic [WIDTH-1:0] OP_HALT = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic             zero_flag,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_data,
    input  logic             instr_ready,
    output logic             stop_en,
    output logic             branch_en,
    output logic [WIDTH-1:0] branch_pc,
    output logic             halted,
    output logic             ret_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_FETCH_TGT,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic             ret_valid_q, ret_valid_d;
    logic             ret_err_q, ret_err_d;

    logic is_nop, is_jmp, is_jz, is_call, is_ret, is_halt;
    logic is_tgt_op, take_tgt;

    assign is_nop    = (ir_q == OP_NOP);
    assign is_jmp    = (ir_q == OP_JMP);
    assign is_jz     = (ir_q == OP_JZ);
    assign is_call   = (ir_q == OP_CALL);
    assign is_ret    = (ir_q == OP_RET);
    assign is_halt   = (ir_q == OP_HALT);
    assign is_tgt_op = is_jmp | is_jz | is_call;
    // JZ only looks at the flag in the cycle its operand arrives
    assign take_tgt  = is_jmp | is_call | (is_jz & zero_flag);

    assign mem_addr   = pc;
    assign instr_data = ir_q;
    assign ret_err    = ret_err_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            ret_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            ret_err_q   <= ret_err_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = ret_valid_q;
        ret_err_d   = ret_err_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_nop) begin
                    state_d = S_FETCH;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_tgt_op) begin
                    state_d = S_FETCH_TGT;
                end else if (is_ret && ret_valid_q) begin
                    ret_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end else if (is_ret) begin
                    ret_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH_TGT: begin
                if (mem_ready) begin
                    if (is_call) begin
                        ret_addr_d  = pc + WIDTH'(1);
                        ret_valid_d = 1'b1;
                    end
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs to memory, execute and the PC; forced idle during reset
    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        stop_en     = 1'b1;
        branch_en   = 1'b0;
        branch_pc   = '0;
        halted      = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                end
                S_DECODE: begin
                    if (is_nop || is_tgt_op) begin
                        stop_en = 1'b0;
                    end else if (is_ret && ret_valid_q) begin
                        stop_en   = 1'b0;
                        branch_en = 1'b1;
                        branch_pc = ret_addr_q;
                    end
                end
                S_ISSUE: begin
                    instr_valid = 1'b1;
                    stop_en     = !instr_ready;
                end
                S_FETCH_TGT: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        stop_en = 1'b0;
                        if (take_tgt) begin
                            branch_en = 1'b1;
                            branch_pc = mem_rdata;
                        end
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    stop_en = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed programs against fetch_ctrl with a PC model,
// a variable-latency memory and fetch/issue scoreboards.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       zero_flag;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic       stop_en;
    logic       branch_en;
    logic [7:0] branch_pc;
    logic       halted;
    logic       ret_err;

    logic [7:0] mem [256];
    int         mem_lat;
    logic [3:0] cnt = 4'd0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] fetch_q [$];
    logic [7:0] issue_q [$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .zero_flag   (zero_flag),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .stop_en     (stop_en),
        .branch_en   (branch_en),
        .branch_pc   (branch_pc),
        .halted      (halted),
        .ret_err     (ret_err)
    );

    // Memory answers mem_lat cycles after a request is raised
    assign mem_ready = mem_req && (int'(cnt) >= mem_lat);
    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (!mem_req || mem_ready) cnt <= 4'd0;
        else if (cnt != 4'd15) cnt <= cnt + 4'd1;
    end

    // Program counter model driven by stop_en/branch_en/branch_pc
    always @(posedge clk) begin
        if (reset) pc <= 8'h00;
        else if (!stop_en) pc <= branch_en ? branch_pc : pc + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: completed fetches and accepted issues
    always @(negedge clk) begin
        if (!reset && mem_req && mem_ready) begin
            checks++;
            assert (fetch_q.size() != 0) else begin
                errors++;
                $error("FAIL fetch_extra observed addr %0h expected none",
                       mem_addr);
            end
            if (fetch_q.size() != 0)
                chk("fetch_addr", 32'(mem_addr), 32'(fetch_q.pop_front()));
        end
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            assert (issue_q.size() != 0) else begin
                errors++;
                $error("FAIL issue_extra observed %0h expected none",
                       instr_data);
            end
            if (issue_q.size() != 0)
                chk("issue_data", 32'(instr_data), 32'(issue_q.pop_front()));
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stop_en", 32'(stop_en), 32'd1);
        chk("rst_branch_en", 32'(branch_en), 32'd0);
        chk("rst_branch_pc", 32'(branch_pc), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_ret_err", 32'(ret_err), 32'd0);
        fetch_q.delete();
        issue_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic end_prog(input logic [7:0] exp_pc);
        wait_halt(300);
        chk("halt_pc", 32'(pc), 32'(exp_pc));
        repeat (3) @(negedge clk);
        chk("halt_no_req", 32'(mem_req), 32'd0);
        chk("halt_pc_held", 32'(pc), 32'(exp_pc));
        chk("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
        chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        zero_flag   = 1'b0;
        instr_ready = 1'b1;
        mem_lat     = 0;
        clear_mem();

        // NOP, NOP, HALT
        mem[8'h00] = 8'h00;
        mem[8'h01] = 8'h00;
        mem[8'h02] = 8'hFF;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'h02};
        repeat (6) @(negedge clk);
        chk("t1_not_halted_in_decode", 32'(halted), 32'd0);
        @(negedge clk);
        chk("t1_halted_after_decode", 32'(halted), 32'd1);
        end_prog(8'h02);

        // JMP 40 -> issue 10
        clear_mem();
        mem[8'h00] = 8'hC0;
        mem[8'h01] = 8'h40;
        mem[8'h40] = 8'h10;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'h40, 8'h41};
        issue_q = '{8'h10};
        repeat (3) @(negedge clk);
        chk("t2_branch_en", 32'(branch_en), 32'd1);
        chk("t2_branch_pc", 32'(branch_pc), 32'h40);
        chk("t2_stop_en", 32'(stop_en), 32'd0);
        @(negedge clk);
        chk("t2_pc_target", 32'(pc), 32'h40);
        end_prog(8'h41);

        // JZ not taken, then taken
        clear_mem();
        mem[8'h00] = 8'hC1;
        mem[8'h01] = 8'h20;
        zero_flag = 1'b0;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'h02};
        end_prog(8'h02);
        zero_flag = 1'b1;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'h20};
        end_prog(8'h20);
        zero_flag = 1'b0;

        // CALL 30 / RET, then RET with empty stack
        clear_mem();
        mem[8'h00] = 8'hC2;
        mem[8'h01] = 8'h30;
        mem[8'h30] = 8'hC3;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'h30, 8'h02};
        end_prog(8'h02);
        chk("t4_ret_err_clear", 32'(ret_err), 32'd0);
        clear_mem();
        mem[8'h00] = 8'hC3;
        do_reset();
        fetch_q = '{8'h00};
        end_prog(8'h00);
        chk("t4_ret_err_set", 32'(ret_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_ret_err_sticky", 32'(ret_err), 32'd1);

        // Stalled issue with slow memory
        clear_mem();
        mem[8'h00] = 8'h55;
        mem_lat     = 3;
        instr_ready = 1'b0;
        do_reset();
        fetch_q = '{8'h00, 8'h01};
        issue_q = '{8'h55};
        repeat (3) begin
            @(negedge clk);
            chk("t5_pc_held_fetch", 32'(pc), 32'h00);
            chk("t5_mem_wait", 32'(mem_ready), 32'd0);
        end
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_instr_valid", 32'(instr_valid), 32'd1);
        repeat (4) begin
            chk("t5_pc_held_issue", 32'(pc), 32'h00);
            chk("t5_instr_data", 32'(instr_data), 32'h55);
            chk("t5_stop_en", 32'(stop_en), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        chk("t5_advance", 32'(stop_en), 32'd0);
        @(posedge clk);
        #1 instr_ready = 1'b0;
        chk("t5_pc_one_step", 32'(pc), 32'h01);
        @(negedge clk);
        chk("t5_pc_still_one", 32'(pc), 32'h01);
        end_prog(8'h01);
        instr_ready = 1'b1;

        // Reset during FETCH_TGT clears the return entry
        clear_mem();
        mem[8'h00] = 8'hC2;
        mem[8'h01] = 8'h10;
        mem[8'h10] = 8'hC0;
        mem[8'h11] = 8'h80;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'h10};
        n = 0;
        while (!(pc == 8'h11 && mem_req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_fetch_tgt", 32'(pc), 32'h11);
        chk("t6_fetches_done", 32'(fetch_q.size()), 32'd0);
        mem[8'h00] = 8'hC3;
        do_reset();
        fetch_q = '{8'h00};
        @(negedge clk);
        chk("t6_req_after_rst", 32'(mem_req), 32'd1);
        chk("t6_pc_restart", 32'(pc), 32'h00);
        end_prog(8'h00);
        chk("t6_ret_valid_cleared", 32'(ret_err), 32'd1);
        mem_lat = 0;

        // Wrap: CALL with operand at FF returns to 00
        clear_mem();
        mem[8'h00] = 8'hC1;
        mem[8'h01] = 8'hFE;
        mem[8'hFE] = 8'hC2;
        mem[8'hFF] = 8'h05;
        mem[8'h05] = 8'hC3;
        zero_flag = 1'b1;
        do_reset();
        fetch_q = '{8'h00, 8'h01, 8'hFE, 8'hFF, 8'h05, 8'h00, 8'h01, 8'h02};
        n = 0;
        while (pc != 8'hFE && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t7_jz_taken", 32'(pc), 32'hFE);
        zero_flag = 1'b0;
        end_prog(8'h02);
        chk("t7_ret_err_clear", 32'(ret_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
